dvp_to_axis: RTL and testbench
==============================

DVP_TO_AXIS -- requirements
Module: dvp_to_axis

Interface
REQ-001 SHALL use one clock; reset is asynchronous and active-high. Clock is i_dvp_pclk and reset is i_dvp_rst. All logic, including the AXIS side, is clocked by i_dvp_pclk.
REQ-002 Parameter P_DVP_DATA_WIDTH, default 8, DVP pixel-bus width.
REQ-003 Parameter P_AXIS_DATA_WIDTH, default 64, AXIS word width; SHALL be an integer multiple N of P_DVP_DATA_WIDTH (default N=8).
REQ-004 Parameter P_FIFO_DEPTH, default 16, output FIFO depth in words; power of 2.
REQ-005 Port i_dvp_pclk, input, 1, sole clock.
REQ-006 Port i_dvp_rst, input, 1, async active-high reset.
REQ-007 Port i_dvp_vsync, input, 1, frame sync; high = blanking/frame restart.
REQ-008 Port i_dvp_href, input, 1, line valid; high = pixel byte present.
REQ-009 Port i_dvp_data, input, P_DVP_DATA_WIDTH, pixel byte.
REQ-010 Port i_axis_clk, input, 1, pin-compatibility only; SHALL be ignored (integrator drives AXIS consumer from i_dvp_pclk).
REQ-011 Port i_dvp_ena, input, 1, capture enable.
REQ-012 Port o_fifo_wr_stat, output, 2, {overflow_sticky, full}.
REQ-013 Port o_fifo_rd_stat, output, clog2(P_FIFO_DEPTH)+1, FIFO occupancy in words.
REQ-014 Port m_axis_tvalid, output, 1, AXIS valid.
REQ-015 Port m_axis_tready, input, 1, AXIS ready.
REQ-016 Port m_axis_tdata, output, P_AXIS_DATA_WIDTH, AXIS data.

Function
REQ-017 Byte capture SHALL occur on a rising edge of i_dvp_pclk when i_dvp_ena=1, i_dvp_href=1 and i_dvp_vsync=0.
REQ-018 Packing: the k-th captured byte of a word (k=0..N-1) SHALL occupy bits [k*W+W-1 : k*W], so the first byte is at the LSB; a lane counter counts 0..N-1 and wraps.
REQ-019 On capture of byte N-1, the complete word SHALL be written into the FIFO on the next rising edge (one-cycle latency). m_axis_tvalid SHALL be high after that edge if the FIFO was empty.
REQ-020 A partial word SHALL persist across href-low gaps; lines need not be multiples of N bytes.
REQ-021 i_dvp_vsync=1 or i_dvp_ena=0 SHALL clear the lane counter and discard any partial word. FIFO contents are kept and continue to drain.
REQ-022 The FIFO SHALL be first-word-fall-through: m_axis_tvalid = (occupancy != 0), and m_axis_tdata = head word, or 0 when empty.
REQ-023 A pop SHALL occur when m_axis_tvalid && m_axis_tready. While m_axis_tvalid=1 and m_axis_tready=0, m_axis_tdata SHALL stay stable.
REQ-024 Push when occupancy = P_FIFO_DEPTH with no simultaneous pop: the word SHALL be dropped and overflow_sticky set. Overflow_sticky is cleared only by reset.
REQ-025 Simultaneous push and pop while full: the push SHALL be accepted and occupancy stays unchanged.
REQ-026 Simultaneous push and pop otherwise: occupancy stays unchanged and order is preserved.
REQ-027 full SHALL equal (occupancy == P_FIFO_DEPTH). o_fifo_rd_stat SHALL equal the registered occupancy.
REQ-028 Read and write pointers SHALL wrap modulo P_FIFO_DEPTH.

Reset
REQ-029 While i_dvp_rst=1, and immediately on its assertion, the following SHALL be 0: lane counter, pack register, FIFO pointers, occupancy, overflow_sticky, full, m_axis_tvalid, m_axis_tdata, o_fifo_rd_stat.
REQ-030 After deassertion, capture SHALL resume on the first qualifying edge. Reset mid-word or mid-frame discards all data.

Verification
REQ-031 Reset: assert i_dvp_rst mid-stream -> m_axis_tvalid=0, m_axis_tdata=0, o_fifo_wr_stat=0, o_fifo_rd_stat=0 without a clock edge.
REQ-032 Packing: ena=1, tready=1, href=1, bytes 0x01..0x08 -> one beat with tdata=0x0807060504030201, tvalid high one cycle after the 8th byte edge.
REQ-033 Frame: vsync pulse of 100 cycles, then 10 lines of 100 incrementing bytes each with 10-cycle href gaps, tready=1 -> exactly 125 beats, bytes contiguous and incrementing across beats, overflow_sticky=0.
REQ-034 vsync flush: 3 bytes, then vsync=1 for 1 cycle, then 8 bytes 0x11..0x18 -> exactly one beat with tdata=0x1817161514131211.
REQ-035 Backpressure: tready=0, 17 words pushed -> full=1 after 16, overflow_sticky=1, head word stable. Then tready=1 -> 16 beats in order, occupancy=0, tvalid=0.
REQ-036 Disable: ena=0 with href/data toggling for 1000 cycles -> no beats, occupancy stays 0.

Source files
------------

// File: rtl/dvp_to_axis.sv
// dvp_to_axis: packs DVP bytes (pclk/rst/vsync/href/data/ena) LSB-first into AXIS words (tvalid/tready/tdata) through a FWFT FIFO, reporting {overflow_sticky, full} and occupancy
module dvp_to_axis #(
  parameter int P_DVP_DATA_WIDTH  = 8,
  parameter int P_AXIS_DATA_WIDTH = 64,
  parameter int P_FIFO_DEPTH      = 16
) (
  input  logic                               i_dvp_pclk,
  input  logic                               i_dvp_rst,
  input  logic                               i_dvp_vsync,
  input  logic                               i_dvp_href,
  input  logic [P_DVP_DATA_WIDTH-1:0]        i_dvp_data,
  input  logic                               i_axis_clk,
  input  logic                               i_dvp_ena,
  output logic [1:0]                         o_fifo_wr_stat,
  output logic [$clog2(P_FIFO_DEPTH):0]      o_fifo_rd_stat,
  output logic                               m_axis_tvalid,
  input  logic                               m_axis_tready,
  output logic [P_AXIS_DATA_WIDTH-1:0]       m_axis_tdata
);
  localparam int DW = P_DVP_DATA_WIDTH;
  localparam int AW = P_AXIS_DATA_WIDTH;
  localparam int N  = AW / DW;
  localparam int LW = N > 1 ? $clog2(N) : 1;
  localparam int PW = P_FIFO_DEPTH > 1 ? $clog2(P_FIFO_DEPTH) : 1;
  localparam int CW = $clog2(P_FIFO_DEPTH) + 1;
  logic [LW-1:0] lane_q, lane_d;
  logic [AW-1:0] pack_q, pack_d;
  logic          push_q, push_d;
  logic [PW-1:0] wp_q, wp_d, rp_q, rp_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          ovf_q, ovf_d;
  logic [AW-1:0] mem_q [P_FIFO_DEPTH];
  logic          cap, clr, full, pop, push, unused_axis_clk;
  assign unused_axis_clk = i_axis_clk;
  assign cap  = i_dvp_ena & i_dvp_href & ~i_dvp_vsync;
  assign clr  = i_dvp_vsync | ~i_dvp_ena;
  assign full = cnt_q == CW'(P_FIFO_DEPTH);
  assign pop  = (cnt_q != '0) & m_axis_tready;
  assign push = push_q & (~full | pop);
  always_comb begin
    lane_d = clr ? '0 : cap ? (lane_q == LW'(N - 1) ? '0 : lane_q + 1'b1) : lane_q;
    pack_d = pack_q;
    if (cap) pack_d[lane_q * DW +: DW] = i_dvp_data;
    push_d = cap & (lane_q == LW'(N - 1));
    wp_d   = push ? wp_q + 1'b1 : wp_q;
    rp_d   = pop ? rp_q + 1'b1 : rp_q;
    cnt_d  = cnt_q + CW'(push) - CW'(pop);
    ovf_d  = ovf_q | (push_q & full & ~pop);
  end
  always_ff @(posedge i_dvp_pclk or posedge i_dvp_rst) begin
    if (i_dvp_rst) begin
      lane_q <= '0;
      pack_q <= '0;
      push_q <= 1'b0;
      wp_q   <= '0;
      rp_q   <= '0;
      cnt_q  <= '0;
      ovf_q  <= 1'b0;
    end else begin
      lane_q <= lane_d;
      pack_q <= pack_d;
      push_q <= push_d;
      wp_q   <= wp_d;
      rp_q   <= rp_d;
      cnt_q  <= cnt_d;
      ovf_q  <= ovf_d;
    end
  end
  // the completed word stays in pack_q for one edge; only lane 0 can be overwritten on the push edge
  always_ff @(posedge i_dvp_pclk) begin
    if (push) mem_q[wp_q] <= pack_q;
  end
  assign m_axis_tvalid  = cnt_q != '0;
  assign m_axis_tdata   = m_axis_tvalid ? mem_q[rp_q] : '0;
  assign o_fifo_rd_stat = cnt_q;
  assign o_fifo_wr_stat = {ovf_q, full};
endmodule

// File: tb/tb_dvp_to_axis.sv
// tb_dvp_to_axis: randomized scoreboard bench for dvp_to_axis against a byte-queue reference model
module tb_dvp_to_axis;
  logic        clk = 1'b0, rst = 1'b1, vs = 1'b0, hr = 1'b0, en = 1'b0, rdy = 1'b0;
  logic [7:0]  d = '0;
  logic [1:0]  wr_stat;
  logic [4:0]  rd_stat;
  logic        tvalid;
  logic [63:0] tdata, pend_w, last_beat;
  int          n_cmp = 0, n_bad = 0, beats = 0, occ = 0, b0;
  bit          ovf_m = 1'b0, pend_v = 1'b0, r;
  logic [7:0]  part [$];
  logic [63:0] sb [$];

  dvp_to_axis dut (
    .i_dvp_pclk(clk), .i_dvp_rst(rst), .i_dvp_vsync(vs), .i_dvp_href(hr),
    .i_dvp_data(d), .i_axis_clk(clk), .i_dvp_ena(en),
    .o_fifo_wr_stat(wr_stat), .o_fifo_rd_stat(rd_stat),
    .m_axis_tvalid(tvalid), .m_axis_tready(rdy), .m_axis_tdata(tdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic model_clear();
    part.delete();
    sb.delete();
    occ = 0;
    ovf_m = 1'b0;
    pend_v = 1'b0;
  endtask

  // reference: bytes gather in a queue; every 8th byte forms a word that enters a 16-deep store one edge later
  task automatic model_edge();
    bit pop;
    if (rst) begin
      model_clear();
      return;
    end
    pop = occ > 0 && rdy;
    if (pend_v) begin
      if (occ < 16 || pop) begin
        sb.push_back(pend_w);
        occ++;
      end else ovf_m = 1'b1;
    end
    if (pop) occ--;
    pend_v = 1'b0;
    if (!en || vs) part.delete();
    else if (hr) begin
      part.push_back(d);
      if (part.size() == 8) begin
        pend_w = '0;
        for (int k = 0; k < 8; k++) pend_w |= 64'(part[k]) << (8 * k);
        pend_v = 1'b1;
        part.delete();
      end
    end
  endtask

  task automatic step(input bit v, input bit h, input logic [7:0] dd, input bit e, input bit rr);
    vs = v; hr = h; d = dd; en = e; rdy = rr;
    @(posedge clk);
    model_edge();
    #1;
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      chk("occupancy", 64'(rd_stat), 64'(occ));
      chk("tvalid", 64'(tvalid), 64'(occ != 0));
      chk("full", 64'(wr_stat[0]), 64'(occ == 16));
      chk("overflow", 64'(wr_stat[1]), 64'(ovf_m));
      if (tvalid && rdy) begin
        if (sb.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL beat_unexpected: got %0h expected no beat", tdata);
        end else chk("beat_data", tdata, sb.pop_front());
        last_beat = tdata;
        beats++;
      end
    end
  end

  initial begin
    repeat (3) step(0, 0, 0, 0, 0);
    rst = 1'b0;
    // asynchronous reset mid-stream
    for (int i = 0; i < 20; i++) step(0, 1, 8'(i), 1, 0);
    rst = 1'b1;
    #1;
    model_clear();
    chk("rst_tvalid", 64'(tvalid), 0);
    chk("rst_tdata", tdata, 0);
    chk("rst_wr_stat", 64'(wr_stat), 0);
    chk("rst_rd_stat", 64'(rd_stat), 0);
    repeat (2) step(0, 0, 0, 0, 0);
    rst = 1'b0;
    // packing
    for (int i = 1; i <= 8; i++) step(0, 1, 8'(i), 1, 1);
    chk("pack_tvalid_early", 64'(tvalid), 0);
    step(0, 0, 0, 1, 1);
    chk("pack_tvalid", 64'(tvalid), 1);
    chk("pack_tdata", tdata, 64'h0807060504030201);
    repeat (2) step(0, 0, 0, 1, 1);
    // frame
    b0 = beats;
    repeat (100) step(1, 0, 0, 1, 1);
    for (int l = 0; l < 10; l++) begin
      for (int p = 0; p < 100; p++) step(0, 1, 8'(l * 100 + p), 1, 1);
      repeat (10) step(0, 0, 0, 1, 1);
    end
    repeat (5) step(0, 0, 0, 1, 1);
    chk("frame_beats", 64'(beats - b0), 125);
    chk("frame_ovf", 64'(wr_stat[1]), 0);
    // vsync flush of a partial word
    b0 = beats;
    for (int i = 0; i < 3; i++) step(0, 1, 8'hAA, 1, 1);
    step(1, 0, 0, 1, 1);
    for (int i = 0; i < 8; i++) step(0, 1, 8'(8'h11 + i), 1, 1);
    repeat (3) step(0, 0, 0, 1, 1);
    chk("flush_beats", 64'(beats - b0), 1);
    chk("flush_tdata", last_beat, 64'h1817161514131211);
    // disable
    b0 = beats;
    repeat (1000) step(($urandom % 2) == 1, ($urandom % 2) == 1, 8'($urandom), 0, 1);
    chk("disable_beats", 64'(beats - b0), 0);
    chk("disable_occ", 64'(rd_stat), 0);
    // backpressure and overflow
    b0 = beats;
    for (int i = 0; i < 128; i++) step(0, 1, 8'(i), 1, 0);
    step(0, 0, 0, 1, 0);
    chk("bp_wr_stat_full", 64'(wr_stat), 64'h1);
    chk("bp_occ_full", 64'(rd_stat), 16);
    chk("bp_head", tdata, 64'h0706050403020100);
    for (int i = 128; i < 136; i++) step(0, 1, 8'(i), 1, 0);
    step(0, 0, 0, 1, 0);
    chk("bp_wr_stat_ovf", 64'(wr_stat), 64'h3);
    chk("bp_head_stable", tdata, 64'h0706050403020100);
    repeat (20) step(0, 0, 0, 1, 1);
    chk("bp_beats", 64'(beats - b0), 16);
    chk("bp_occ_empty", 64'(rd_stat), 0);
    chk("bp_tvalid_empty", 64'(tvalid), 0);
    // randomized traffic with alternating light and heavy backpressure
    rst = 1'b1;
    #1;
    model_clear();
    step(0, 0, 0, 0, 0);
    rst = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      r = ((i / 400) % 2 == 1) ? ($urandom % 8 == 0) : ($urandom % 4 != 0);
      step($urandom % 60 == 0, $urandom % 5 != 0, 8'($urandom), $urandom % 30 != 0, r);
    end
    repeat (40) step(0, 0, 0, 1, 1);
    chk("rand_ovf", 64'(wr_stat[1]), 64'(ovf_m));
    chk("rand_occ_empty", 64'(rd_stat), 0);
    chk("rand_sb_empty", 64'(sb.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
